// File: rtl/ppu_pixel_fifo_n_pkg.sv
// Shared types for the PPU pixel FIFO: pixel format, tile row width, discard FSM states.
package ppu_pixel_fifo_n_pkg;

    localparam int unsigned PPU_TILE_ROW = 8;

    // color == 0 is transparent
    typedef struct packed {
        logic       bg_priority;
        logic [2:0] palette;
        logic [1:0] color;
    } ppu_pixel_t;

    typedef enum logic [0:0] {
        IDLE,
        DISCARD
    } ppu_fifo_state_e;

    function automatic logic px_opaque(input ppu_pixel_t p);
        return p.color != 2'd0;
    endfunction

endpackage

// File: rtl/ppu_pixel_fifo_n_if.sv
// Push/pop handshake bundle between tile fetcher, pixel FIFO and pixel mixer.
interface ppu_pixel_fifo_n_if
    import ppu_pixel_fifo_n_pkg::*;
#(
    parameter int unsigned ROW = PPU_TILE_ROW
);

    logic                     row_push_en;
    ppu_pixel_t [ROW-1:0]     row_push_px;
    logic                     merge_en;
    logic                     row_ready;
    logic                     pop_en;
    ppu_pixel_t               top_px;
    logic                     px_valid;

    modport master (
        output row_push_en, row_push_px, merge_en, pop_en,
        input  row_ready, top_px, px_valid
    );

    modport slave (
        input  row_push_en, row_push_px, merge_en, pop_en,
        output row_ready, top_px, px_valid
    );

endinterface

// File: rtl/ppu_pixel_fifo_n_discard_ctl.sv
// SCX fine-scroll discard engine: drops discard_n head pixels, one per non-empty cycle.
module ppu_pixel_fifo_n_discard_ctl
    import ppu_pixel_fifo_n_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       flush,
    input  logic       discard_start,
    input  logic [2:0] discard_n,
    input  logic       empty,
    input  logic       stall,
    output logic       discard_busy,
    output logic       drop
);

    ppu_fifo_state_e state_q, state_d;
    logic [2:0]      remaining_q, remaining_d;

    // Next state, remaining counter and internal pop strobe
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        drop        = 1'b0;
        case (state_q)
            IDLE: begin
                if (discard_start && discard_n != 3'd0) begin
                    state_d     = DISCARD;
                    remaining_d = discard_n;
                end
            end
            DISCARD: begin
                if (!empty && !stall) begin
                    drop        = 1'b1;
                    remaining_d = remaining_q - 3'd1;
                    if (remaining_q == 3'd1) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (flush) begin
            state_d     = IDLE;
            remaining_d = 3'd0;
            drop        = 1'b0;
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            remaining_q <= 3'd0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
        end
    end

    assign discard_busy = (state_q == DISCARD);

endmodule

// File: rtl/ppu_pixel_fifo_n.sv
// Row-push / pixel-pop PPU FIFO with SCX discard engine.
// Optional sprite merge (overlay onto head pixels) enabled by defining PPU_FIFO_MERGE_EN.
module ppu_pixel_fifo_n
    import ppu_pixel_fifo_n_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned ROW   = PPU_TILE_ROW
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    ppu_pixel_fifo_n_if.slave        fifo,
    input  logic                     discard_start,
    input  logic [2:0]               discard_n,
    output logic                     discard_busy,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned AW = CW - 1;

    logic [CW-1:0]  rptr_q, rptr_d, wptr_q, wptr_d;
    ppu_pixel_t     mem_q [DEPTH];
    logic [DEPTH-1:0] mem_we;
    ppu_pixel_t     mem_wd [DEPTH];
    logic           merge_req;
    logic           push_ok;
    logic           pop_ok;
    logic           drop;

    assign count = wptr_q - rptr_q;
    assign empty = (count == '0);

`ifdef PPU_FIFO_MERGE_EN
    assign merge_req = fifo.row_push_en & fifo.merge_en;
`else
    assign merge_req = 1'b0;
    logic unused_merge_en;
    assign unused_merge_en = fifo.merge_en;
`endif

    // Merge rewrites the head row in place, so it only fits while at most one row is queued
    assign fifo.row_ready = merge_req ? (count <= CW'(ROW)) : (count <= CW'(DEPTH - ROW));
    assign push_ok        = fifo.row_push_en & fifo.row_ready & ~flush;

    // Head pixel is hidden while discarding and during a merge cycle
    assign fifo.px_valid = ~empty & ~discard_busy & ~merge_req;
    assign fifo.top_px   = fifo.px_valid ? mem_q[rptr_q[AW-1:0]] : '0;
    assign pop_ok        = fifo.pop_en & fifo.px_valid;

    ppu_pixel_fifo_n_discard_ctl u_discard_ctl (
        .clk           (clk),
        .reset         (reset),
        .flush         (flush),
        .discard_start (discard_start),
        .discard_n     (discard_n),
        .empty         (empty),
        .stall         (merge_req),
        .discard_busy  (discard_busy),
        .drop          (drop)
    );

    // Per-entry write enables/data for append or merge
    always_comb begin
        logic [AW-1:0] idx;
        idx    = '0;
        mem_we = '0;
        for (int d = 0; d < DEPTH; d++) begin
            mem_wd[d] = '0;
        end
        if (push_ok) begin
            for (int i = 0; i < ROW; i++) begin
                idx = merge_req ? (rptr_q[AW-1:0] + AW'(i)) : (wptr_q[AW-1:0] + AW'(i));
                // Earlier sprite wins unless it is transparent there
                if (!merge_req || CW'(i) >= count ||
                    (!px_opaque(mem_q[idx]) && px_opaque(fifo.row_push_px[i]))) begin
                    mem_we[idx] = 1'b1;
                    mem_wd[idx] = fifo.row_push_px[i];
                end
            end
        end
    end

    // Pixel storage; contents deliberately not reset
    always_ff @(posedge clk) begin
        for (int d = 0; d < DEPTH; d++) begin
            if (mem_we[d]) begin
                mem_q[d] <= mem_wd[d];
            end
        end
    end

    // Pointer next-state; pop/drop are already suppressed in merge cycles
    always_comb begin
        rptr_d = rptr_q;
        wptr_d = wptr_q;
        if (flush) begin
            rptr_d = '0;
            wptr_d = '0;
        end else begin
            if (pop_ok || drop) begin
                rptr_d = rptr_q + CW'(1);
            end
            if (push_ok) begin
                wptr_d = merge_req ? (rptr_q + CW'(ROW)) : (wptr_q + CW'(ROW));
            end
        end
    end

    // Pointer registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rptr_q <= '0;
            wptr_q <= '0;
        end else begin
            rptr_q <= rptr_d;
            wptr_q <= wptr_d;
        end
    end

endmodule

// File: tb/tb_ppu_pixel_fifo_n.sv
// Scoreboard bench for ppu_pixel_fifo_n: stimulus queues expected pixels, a negedge
// monitor pops and compares whenever the DUT consumes a valid head pixel.
module tb_ppu_pixel_fifo_n;
    import ppu_pixel_fifo_n_pkg::*;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned ROW   = 8;

    logic       clk;
    logic       reset;
    logic       flush;
    logic       discard_start;
    logic [2:0] discard_n;
    logic       discard_busy;
    logic       empty;
    logic [4:0] count;

    ppu_pixel_fifo_n_if #(.ROW(ROW)) fifo ();

    ppu_pixel_fifo_n #(.DEPTH(DEPTH), .ROW(ROW)) dut (
        .clk           (clk),
        .reset         (reset),
        .flush         (flush),
        .fifo          (fifo.slave),
        .discard_start (discard_start),
        .discard_n     (discard_n),
        .discard_busy  (discard_busy),
        .empty         (empty),
        .count         (count)
    );

    int total = 0;
    int bad   = 0;
    ppu_pixel_t exp_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic ppu_pixel_t mk(input int r, input int i);
        ppu_pixel_t p;
        int c;
        c             = i + r;
        p.bg_priority = r[0];
        p.palette     = i[2:0];
        p.color       = c[1:0];
        return p;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_row(input int r);
        for (int i = 0; i < ROW; i++) fifo.row_push_px[i] = mk(r, i);
    endtask

    task automatic exp_row(input int r);
        for (int i = 0; i < ROW; i++) exp_q.push_back(mk(r, i));
    endtask

    task automatic pops(input int n);
        fifo.pop_en = 1'b1;
        repeat (n) tick();
        fifo.pop_en = 1'b0;
    endtask

    // Monitor: every accepted pop must return the oldest expected pixel
    always @(negedge clk) begin
        if (reset && fifo.pop_en && fifo.px_valid) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL pop_unexpected: got %0h expected none", fifo.top_px);
            end else begin
                ppu_pixel_t e;
                e = exp_q.pop_front();
                if (fifo.top_px !== e) begin
                    bad++;
                    $display("FAIL pop_data: got %0h expected %0h", fifo.top_px, e);
                end
            end
        end
    end

    initial begin
        int n;
        reset              = 1'b0;
        flush              = 1'b0;
        discard_start      = 1'b0;
        discard_n          = 3'd0;
        fifo.row_push_en   = 1'b0;
        fifo.merge_en      = 1'b0;
        fifo.pop_en        = 1'b0;
        fifo.row_push_px   = '0;

        // Reset state
        repeat (3) tick();
        chk("rst_count", 32'(count), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_ready", 32'(fifo.row_ready), 1);
        chk("rst_valid", 32'(fifo.px_valid), 0);
        chk("rst_top", 32'(fifo.top_px), 0);
        chk("rst_busy", 32'(discard_busy), 0);
        reset = 1'b1;
        tick();

        // Single row: one-cycle latency, in-order pops
        set_row(0);
        fifo.row_push_en = 1'b1;
        exp_row(0);
        tick();
        fifo.row_push_en = 1'b0;
        chk("row_count", 32'(count), 8);
        chk("row_valid", 32'(fifo.px_valid), 1);
        chk("row_head_color", 32'(fifo.top_px.color), 0);
        pops(8);
        chk("row_drained", 32'(empty), 1);

        // Pop while empty is ignored
        pops(1);
        chk("pop_empty_ignored", 32'(count), 0);

        // Full boundary
        fifo.row_push_en = 1'b1;
        set_row(1); exp_row(1); tick();
        chk("full_at8_ready", 32'(fifo.row_ready), 1);
        set_row(2); exp_row(2); tick();
        chk("full_count", 32'(count), 16);
        chk("full_ready", 32'(fifo.row_ready), 0);
        set_row(3); tick();
        fifo.row_push_en = 1'b0;
        chk("full_drop", 32'(count), 16);
        pops(1);
        chk("full_15_count", 32'(count), 15);
        chk("full_15_ready", 32'(fifo.row_ready), 0);
        pops(7);
        chk("full_8_ready", 32'(fifo.row_ready), 1);

        // Simultaneous push+pop across pointer wrap
        for (int k = 0; k < 4; k++) begin
            set_row(40 + k);
            exp_row(40 + k);
            fifo.row_push_en = 1'b1;
            fifo.pop_en      = 1'b1;
            tick();
            fifo.row_push_en = 1'b0;
            chk("simul_count", 32'(count), 15);
            pops(7);
            chk("simul_back8", 32'(count), 8);
        end
        pops(8);
        chk("simul_drained", 32'(empty), 1);

        // Discard 5 of a loaded row; pop_en ignored while busy
        set_row(10); exp_row(10);
        fifo.row_push_en = 1'b1;
        tick();
        fifo.row_push_en = 1'b0;
        discard_start = 1'b1;
        discard_n     = 3'd5;
        repeat (5) void'(exp_q.pop_front());
        tick();
        discard_start = 1'b0;
        fifo.pop_en   = 1'b1;
        for (int k = 0; k < 5; k++) begin
            chk("disc_busy", 32'(discard_busy), 1);
            chk("disc_count", 32'(count), 32'(8 - k));
            tick();
        end
        fifo.pop_en = 1'b0;
        chk("disc_done", 32'(discard_busy), 0);
        chk("disc_left", 32'(count), 3);
        chk("disc_head_pal", 32'(fifo.top_px.palette), 5);
        pops(3);

        // Discard from empty waits for a push
        discard_start = 1'b1;
        discard_n     = 3'd5;
        tick();
        discard_start = 1'b0;
        repeat (3) tick();
        chk("disc_wait_busy", 32'(discard_busy), 1);
        chk("disc_wait_count", 32'(count), 0);
        set_row(11); exp_row(11);
        repeat (5) void'(exp_q.pop_front());
        fifo.row_push_en = 1'b1;
        tick();
        fifo.row_push_en = 1'b0;
        n = 0;
        while (discard_busy && n < 20) begin
            tick();
            n++;
        end
        chk("disc_wait_done", 32'(discard_busy), 0);
        chk("disc_wait_left", 32'(count), 3);
        pops(3);

        // discard_n == 0 is a no-op
        discard_start = 1'b1;
        discard_n     = 3'd0;
        tick();
        discard_start = 1'b0;
        chk("disc_zero", 32'(discard_busy), 0);

        // Flush aborts a discard in progress
        set_row(12);
        fifo.row_push_en = 1'b1;
        tick();
        fifo.row_push_en = 1'b0;
        discard_start = 1'b1;
        discard_n     = 3'd7;
        tick();
        discard_start = 1'b0;
        repeat (2) tick();
        chk("flush_pre_count", 32'(count), 6);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_count", 32'(count), 0);
        chk("flush_busy", 32'(discard_busy), 0);
        chk("flush_valid", 32'(fifo.px_valid), 0);
        chk("flush_ready", 32'(fifo.row_ready), 1);

`ifdef PPU_FIFO_MERGE_EN
        begin
            ppu_pixel_t m [ROW];
            ppu_pixel_t old [$];
            logic [1:0] cols [ROW];
            cols = '{2'd1, 2'd1, 2'd1, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3};
            // Leave {0,2,0} in the FIFO
            set_row(30);
            fifo.row_push_px[5].color = 2'd0;
            fifo.row_push_px[6].color = 2'd2;
            fifo.row_push_px[7].color = 2'd0;
            for (int i = 0; i < ROW; i++) exp_q.push_back(fifo.row_push_px[i]);
            fifo.row_push_en = 1'b1;
            tick();
            fifo.row_push_en = 1'b0;
            pops(5);
            chk("merge_pre_count", 32'(count), 3);
            for (int i = 0; i < ROW; i++) begin
                m[i]       = mk(31, i);
                m[i].color = cols[i];
                fifo.row_push_px[i] = m[i];
            end
            old = exp_q;
            exp_q.delete();
            exp_q.push_back(m[0]);
            exp_q.push_back(old[1]);
            for (int i = 2; i < ROW; i++) exp_q.push_back(m[i]);
            fifo.row_push_en = 1'b1;
            fifo.merge_en    = 1'b1;
            fifo.pop_en      = 1'b1;
            #1;
            chk("merge_ready", 32'(fifo.row_ready), 1);
            chk("merge_valid_off", 32'(fifo.px_valid), 0);
            tick();
            fifo.row_push_en = 1'b0;
            fifo.merge_en    = 1'b0;
            fifo.pop_en      = 1'b0;
            chk("merge_count", 32'(count), 8);
            chk("merge_head_color", 32'(fifo.top_px.color), 1);
            pops(8);
            // Merge rejected above one row
            fifo.row_push_en = 1'b1;
            set_row(32); exp_row(32); tick();
            set_row(33); exp_row(33); tick();
            fifo.row_push_en = 1'b0;
            pops(7);
            chk("merge9_count", 32'(count), 9);
            set_row(34);
            fifo.row_push_en = 1'b1;
            fifo.merge_en    = 1'b1;
            #1;
            chk("merge9_ready", 32'(fifo.row_ready), 0);
            tick();
            fifo.row_push_en = 1'b0;
            fifo.merge_en    = 1'b0;
            chk("merge9_kept", 32'(count), 9);
            flush = 1'b1;
            tick();
            flush = 1'b0;
            exp_q.delete();
        end
`else
        // merge_en has no effect: both pushes append
        fifo.merge_en    = 1'b1;
        fifo.row_push_en = 1'b1;
        set_row(50); exp_row(50); tick();
        set_row(51); exp_row(51); tick();
        fifo.row_push_en = 1'b0;
        fifo.merge_en    = 1'b0;
        chk("nomerge_count", 32'(count), 16);
        pops(16);
`endif

        chk("end_count", 32'(count), 0);
        chk("end_scoreboard", 32'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard time bound so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
